ps2_scan_controller: RTL

- Sequences the byte stream from the PS/2 receiver, which delivers an 8-bit scan code plus a one-cycle done pulse.
- Parses Set-2 prefixes (0xE0 extended, 0xF0 break) into complete key events.
- Tracks modifier keys and filters keyboard housekeeping bytes.
- Buffers events in a small FWFT FIFO behind a valid/ready handshake for the downstream consumer (display/control logic).

---
 rtl/ps2_scan_controller.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/ps2_scan_controller.sv
// PS/2 Set-2 scan code sequencer: turns the raw receiver byte stream into key events.
// It also tracks the shift/ctrl modifiers and queues events in a first-word-fall-through FIFO.
module ps2_scan_controller #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int TO_W           = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_break,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic       shift_held,
  output logic       ctrl_held,
  output logic       seq_err,
  output logic       overflow,
  input  logic       clr_overflow
);

  localparam int ADDR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int PTR_W  = ADDR_W + 1;
  localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] FULL_XOR = PTR_W'(1) << ADDR_W;

  localparam logic [7:0] PFX_EXT = 8'hE0;
  localparam logic [7:0] PFX_BRK = 8'hF0;

  typedef enum logic [1:0] {IDLE, E0, F0, E0F0} state_t;

  state_t           state, next_state;
  logic [TO_W-1:0]  to_cnt;
  logic             emit, emit_ext, emit_brk, err;
  logic             housekeeping;

  logic             lshift, rshift, lctrl, rctrl;

  logic [9:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             empty, full, pop, push, drop;

  // Keyboard self-test / ack / resend bytes never form key events.
  always_comb begin
    housekeeping = 1'b0;
    case (scan_code)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: housekeeping = 1'b1;
      default:                                  housekeeping = 1'b0;
    endcase
  end

  always_comb begin
    next_state = state;
    emit       = 1'b0;
    emit_ext   = 1'b0;
    emit_brk   = 1'b0;
    err        = 1'b0;
    if (scan_valid) begin
      case (state)
        IDLE: begin
          if (scan_code == PFX_EXT)      next_state = E0;
          else if (scan_code == PFX_BRK) next_state = F0;
          else if (!housekeeping)        emit = 1'b1;
        end
        E0: begin
          if (scan_code == PFX_BRK) next_state = E0F0;
          else if (scan_code != PFX_EXT) begin
            emit       = 1'b1;
            emit_ext   = 1'b1;
            next_state = IDLE;
          end
        end
        F0: begin
          next_state = IDLE;
          if (scan_code == PFX_EXT || scan_code == PFX_BRK) err = 1'b1;
          else begin
            emit     = 1'b1;
            emit_brk = 1'b1;
          end
        end
        default: begin
          next_state = IDLE;
          if (scan_code == PFX_EXT || scan_code == PFX_BRK) err = 1'b1;
          else begin
            emit     = 1'b1;
            emit_ext = 1'b1;
            emit_brk = 1'b1;
          end
        end
      endcase
    end else if (state != IDLE && to_cnt == TO_LIMIT) begin
      next_state = IDLE;
      err        = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      to_cnt  <= '0;
      seq_err <= 1'b0;
    end else begin
      state   <= next_state;
      seq_err <= err;
      if (scan_valid || next_state == IDLE || state == IDLE) to_cnt <= '0;
      else                                                   to_cnt <= to_cnt + TO_W'(1);
    end
  end

  // Modifiers follow every parsed event, even ones the FIFO has to drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lshift <= 1'b0;
      rshift <= 1'b0;
      lctrl  <= 1'b0;
      rctrl  <= 1'b0;
    end else if (emit) begin
      if (scan_code == 8'h12) lshift <= !emit_brk;
      if (scan_code == 8'h59) rshift <= !emit_brk;
      if (scan_code == 8'h14) begin
        if (emit_ext) rctrl <= !emit_brk;
        else          lctrl <= !emit_brk;
      end
    end
  end

  assign shift_held = lshift | rshift;
  assign ctrl_held  = lctrl | rctrl;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = ((wr_ptr ^ rd_ptr) == FULL_XOR);
  assign pop   = !empty && evt_ready;
  assign push  = emit && (!full || pop);
  assign drop  = emit && full && !pop;

  // A full FIFO still accepts a write when the head is popped in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[ADDR_W-1:0]] <= {emit_ext, emit_brk, scan_code};
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      if (drop)              overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

  assign evt_valid = !empty;
  assign evt_ext   = mem[rd_ptr[ADDR_W-1:0]][9];
  assign evt_break = mem[rd_ptr[ADDR_W-1:0]][8];
  assign evt_code  = mem[rd_ptr[ADDR_W-1:0]][7:0];

endmodule
